// File: rtl/bram_pkg.sv
// Shared defaults, FSM encoding and read latency for the BRAM responder.
// LAT is 2 when BRAM_OUT_REG_EN is defined, otherwise 1.
package bram_pkg;

  localparam int unsigned DefDataWidth = 16;
  localparam int unsigned DefMemSize   = 4095;

  typedef enum logic {
    StInit  = 1'b0,
    StReady = 1'b1
  } bram_state_e;

`ifdef BRAM_OUT_REG_EN
  localparam int unsigned LAT = 2;
`else
  localparam int unsigned LAT = 1;
`endif

endpackage

// File: rtl/bram_array.sv
// Plain synchronous single-port storage with a registered, no-change read port.
// Contents are never reset so the array maps onto block RAM.
module bram_array
  import bram_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DefDataWidth,
  parameter int unsigned MEM_SIZE   = DefMemSize,
  parameter int unsigned ADDR_WIDTH = $clog2(MEM_SIZE)
) (
  input  logic                  clk,
  input  logic                  i_en,
  input  logic                  i_we,
  input  logic [ADDR_WIDTH-1:0] i_addr,
  input  logic [DATA_WIDTH-1:0] i_din,
  output logic [DATA_WIDTH-1:0] o_dout
);

  logic [DATA_WIDTH-1:0] r_mem [MEM_SIZE];
  logic [DATA_WIDTH-1:0] r_dout;

  // Writes leave the read register untouched so it only moves on reads.
  always_ff @(posedge clk) begin
    if (i_en) begin
      if (i_we) begin
        r_mem[i_addr] <= i_din;
      end else begin
        r_dout <= r_mem[i_addr];
      end
    end
  end

  assign o_dout = r_dout;

endmodule

// File: rtl/bram_resp.sv
// Memory-side BRAM responder: zero-fill sweep after reset, range-checked accesses,
// sticky error flag. Define BRAM_OUT_REG_EN for an extra output register (LAT=2).
module bram_resp
  import bram_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DefDataWidth,
  parameter int unsigned MEM_SIZE   = DefMemSize,
  parameter int unsigned ADDR_WIDTH = $clog2(MEM_SIZE)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] din,
  output logic [DATA_WIDTH-1:0] qout,
  output logic                  o_rvalid,
  output logic                  o_ready,
  output logic                  o_err,
  input  logic                  i_err_clr
);

  bram_state_e           r_state, w_state_nxt;
  logic [ADDR_WIDTH-1:0] r_init_addr, w_init_addr_nxt;

  logic                  w_ready, w_in_range, w_acc, w_rd;
  logic                  w_arr_en, w_arr_we;
  logic [ADDR_WIDTH-1:0] w_arr_addr;
  logic [DATA_WIDTH-1:0] w_arr_din, w_dout, w_q1;
  logic                  r_rvalid1, r_rd_ok, r_err;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= StInit;
      r_init_addr <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_init_addr <= w_init_addr_nxt;
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_init_addr_nxt = r_init_addr;
    unique case (r_state)
      StInit: begin
        if (r_init_addr == ADDR_WIDTH'(MEM_SIZE - 1)) begin
          w_state_nxt     = StReady;
          w_init_addr_nxt = '0;
        end else begin
          w_init_addr_nxt = r_init_addr + 1'b1;
        end
      end
      StReady: begin
        w_state_nxt = StReady;
      end
    endcase
  end

  assign w_ready    = (r_state == StReady);
  assign w_in_range = ({1'b0, addr} < (ADDR_WIDTH + 1)'(MEM_SIZE));
  assign w_acc      = w_ready & en;
  assign w_rd       = w_acc & ~we;

  // The sweep owns the array during INIT; afterwards only in-range requests reach it.
  assign w_arr_en   = ~w_ready | (w_acc & w_in_range);
  assign w_arr_we   = ~w_ready | we;
  assign w_arr_addr = w_ready ? addr : r_init_addr;
  assign w_arr_din  = w_ready ? din : '0;

  bram_array #(
    .DATA_WIDTH (DATA_WIDTH),
    .MEM_SIZE   (MEM_SIZE),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_array (
    .clk    (clk),
    .i_en   (w_arr_en),
    .i_we   (w_arr_we),
    .i_addr (w_arr_addr),
    .i_din  (w_arr_din),
    .o_dout (w_dout)
  );

  // r_rd_ok masks the unreset array register: 0 after reset or an out-of-range read.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rvalid1 <= 1'b0;
      r_rd_ok   <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      r_rvalid1 <= w_rd;
      if (w_rd) begin
        r_rd_ok <= w_in_range;
      end
      if (w_acc && !w_in_range) begin
        r_err <= 1'b1;
      end else if (i_err_clr) begin
        r_err <= 1'b0;
      end
    end
  end

  assign w_q1    = r_rd_ok ? w_dout : '0;
  assign o_ready = w_ready;
  assign o_err   = r_err;

`ifdef BRAM_OUT_REG_EN
  logic [DATA_WIDTH-1:0] r_q2;
  logic                  r_rvalid2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_q2      <= '0;
      r_rvalid2 <= 1'b0;
    end else begin
      r_rvalid2 <= r_rvalid1;
      if (r_rvalid1) begin
        r_q2 <= w_q1;
      end
    end
  end

  assign qout     = r_q2;
  assign o_rvalid = r_rvalid2;
`else
  assign qout     = w_q1;
  assign o_rvalid = r_rvalid1;
`endif

endmodule
